// File: rtl/proc_mem_arbiter.sv
// Arbitrates IF and LS requesters onto one fixed-latency synchronous memory port.
// Define ARB_PERF_CNT_EN to add per-requester 16-bit grant counters.
module proc_mem_arbiter #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_LIM = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]   if_grant_cnt,
    output logic [15:0]   ls_grant_cnt,
`endif
    output logic          busy
);

    localparam int unsigned LW = $clog2(MEM_LAT + 1);
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          r_state, w_next;
    logic            r_owner_ls;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_ls_rdata;
    logic [LW-1:0]   r_lat;
    logic [SW-1:0]   r_starve;
    logic            w_any_req;
    logic            w_pick_if;
    logic            w_last;
`ifdef ARB_PERF_CNT_EN
    logic [15:0]     r_if_cnt;
    logic [15:0]     r_ls_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        ls_ack    = 1'b0;
        busy      = (r_state != StIdle);
        w_any_req = if_req | ls_req;
        // LS wins ties unless IF has been passed over STARVE_LIM times
        w_pick_if = if_req & (~ls_req | (r_starve == SW'(STARVE_LIM)));
        w_last    = (r_lat == LW'(1));
        unique case (r_state)
            StIdle: begin
                if (w_any_req) w_next = StIssue;
            end
            StIssue: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                w_next    = StWait;
            end
            StWait: begin
                if (w_last) w_next = StDone;
            end
            StDone: begin
                if_ack = ~r_owner_ls;
                ls_ack = r_owner_ls;
                w_next = StIdle;
            end
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
            r_lat      <= '0;
            r_starve   <= '0;
`ifdef ARB_PERF_CNT_EN
            r_if_cnt   <= '0;
            r_ls_cnt   <= '0;
`endif
        end else if (r_state == StIdle) begin
            if (w_any_req) begin
                r_owner_ls <= ~w_pick_if;
                r_we       <= ~w_pick_if & ls_we;
                r_addr     <= w_pick_if ? if_addr : ls_addr;
                r_wdata    <= w_pick_if ? '0 : ls_wdata;
                if (w_pick_if) begin
                    r_starve <= '0;
                end else if (if_req && (r_starve != SW'(STARVE_LIM))) begin
                    r_starve <= r_starve + SW'(1);
                end
            end
        end else if (r_state == StIssue) begin
            r_lat <= LW'(MEM_LAT);
`ifdef ARB_PERF_CNT_EN
            if (r_owner_ls) r_ls_cnt <= r_ls_cnt + 16'd1;
            else            r_if_cnt <= r_if_cnt + 16'd1;
`endif
        end else if (r_state == StWait) begin
            r_lat <= r_lat - LW'(1);
            // Stores leave both read-data registers untouched
            if (w_last && !r_we) begin
                if (r_owner_ls) r_ls_rdata <= mem_rdata;
                else            r_if_rdata <= mem_rdata;
            end
        end
    end

    assign if_rdata = r_if_rdata;
    assign ls_rdata = r_ls_rdata;
`ifdef ARB_PERF_CNT_EN
    assign if_grant_cnt = r_if_cnt;
    assign ls_grant_cnt = r_ls_cnt;
`endif

endmodule
